alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Single-ALU execution pipe on the consumer side of the ALU reservation-station issue port.
- Accepts one issued ALU op per cycle with a valid/ready handshake and reads both source operands from the physical register file (PRF).
- Computes the RV32I integer result and holds it in an output register until the CDB/writeback arbiter accepts it.
- Two instances are built, one per ALU slot. Each drives its own alu_rdy back to the reservation station.

Parameters:
- XLEN, 32, datapath width.
- PREG_W, 8, physical register index width.
- ROB_W, 4, ROB index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  reservation station presents an op.
- alu_rdy  out  1  unit can accept an op this cycle.
- issue_opcode  in  7  RISC-V opcode.
- issue_func3  in  3  funct3.
- issue_func7  in  7  funct7.
- issue_prd  in  PREG_W  destination physical register.
- issue_pr1  in  PREG_W  source 1 physical register.
- issue_pr2  in  PREG_W  source 2 physical register.
- issue_imm  in  XLEN  sign-extended immediate; LUI immediate is pre-shifted.
- issue_rob_index  in  ROB_W  ROB tag.
- prf_raddr1  out  PREG_W  PRF read address 1.
- prf_raddr2  out  PREG_W  PRF read address 2.
- prf_rdata1  in  XLEN  PRF read data 1, valid the cycle after the address.
- prf_rdata2  in  XLEN  PRF read data 2, valid the cycle after the address.
- flush  in  1  mispredict squash.
- cdb_valid  out  1  result valid.
- cdb_ready  in  1  arbiter accepts the result.
- cdb_prd  out  PREG_W  result destination register.
- cdb_data  out  XLEN  result value.
- cdb_rob_index  out  ROB_W  result ROB tag.
- illegal_op  out  1  the held result came from an unsupported opcode.

Behaviour:
- Pipeline stages:
  - RR register: holds the op's control fields while the PRF read is in flight. Flag rr_valid.
  - WB register: holds the computed result. Flag wb_valid.
- Handshakes:
  - Accept: issue_valid && alu_rdy.
  - Output transfer: cdb_valid && cdb_ready.
- Advance and ready logic (combinational):
  - rr_adv = rr_valid && (!wb_valid || cdb_ready).
  - alu_rdy = !flush && (!rr_valid || rr_adv).
- PRF read addresses: prf_raddr1 = issue_pr1 and prf_raddr2 = issue_pr2, combinational, every cycle.
- Operand capture:
  - In the cycle after an accept, prf_rdata1 and prf_rdata2 are captured into RR operand registers. This capture does not depend on rr_adv, so an RR op stalled behind a full WB keeps its operands.
  - The unit does not bypass or forward. The reservation station issues an op only once its sources are written.
- Latency: an op accepted at edge N has cdb_valid=1 at edge N+2 when there is no back-pressure. Throughput is 1 op/cycle while cdb_ready=1.
- Execute (combinational from RR to WB):
  - opcode 0110011 (R-type), on a = rs1 and b = rs2:
    - func3 000: ADD, or SUB when func7[5]=1.
    - 001: SLL, shift amount b[4:0].
    - 010: SLT, signed compare.
    - 011: SLTU, unsigned compare.
    - 100: XOR.
    - 101: SRL, or SRA when func7[5]=1.
    - 110: OR.
    - 111: AND.
  - opcode 0010011 (I-type): same operations with b = imm. func7[5] is ignored for func3 000 (always ADD). For func3 101 the shift is SRAI when imm[10]=1, SRLI otherwise.
  - opcode 0110111 (LUI): result = imm.
  - Any other opcode: result = 0, illegal_op=1 alongside the result, cdb_valid still asserted.
- WB register update:
  - Loads on rr_adv.
  - Clears wb_valid on an output transfer with no simultaneous rr_adv.
  - Outputs hold stable while cdb_valid=1 && cdb_ready=0.
- Flush (synchronous): on an edge with flush=1, rr_valid and wb_valid are cleared and any accept in that cycle is blocked. flush has priority over the handshakes.
- Reset: rr_valid=0, wb_valid=0, cdb_valid=0, cdb_prd=0, cdb_data=0, cdb_rob_index=0, illegal_op=0. alu_rdy=1 in the first cycle after reset deasserts. Reset applied mid-operation discards all in-flight ops.
- Boundary conditions:
  - Full stall (both stages valid, cdb_ready=0): alu_rdy=0 and nothing changes.
  - Accept, advance and output transfer in the same cycle: all three take effect together with no bubble.

Optional Feature:
- Macro: ALU_EXEC_PERF_EN.
- When defined:
  - Adds output ops_done [31:0], which counts output transfers.
  - Adds output stall_cycles [31:0], which counts cycles with issue_valid=1 && alu_rdy=0.
  - Both counters reset to 0, are not affected by flush, and wrap at 2^32.
- When undefined: neither port nor counter exists.

Test Plan:
- Reset, then check: alu_rdy=1, cdb_valid=0, cdb_data=0.
- ADD with pr1 data 5, pr2 data 7, prd=12, rob 3, cdb_ready=1 -> cdb_valid two cycles later with cdb_data=12, cdb_prd=12, cdb_rob_index=3.
- SUB 3-5 -> 0xFFFFFFFE.
- SRA 0x80000000 by 4 -> 0xF8000000.
- SLTU 1 vs 0xFFFFFFFF -> 1.
- SRAI with imm 0x404 on 0x80000000 -> 0xF8000000.
- LUI imm 0x12345000 -> 0x12345000.
- Back-pressure: cdb_ready=0 with three back-to-back issues -> the first two are held (alu_rdy drops after the second accept) and the result is unchanged. Raise cdb_ready -> results delivered in order, no loss or duplication.
- Flush with both stages valid -> cdb_valid=0 next cycle and alu_rdy=0 during the flush cycle. An issue in the flush cycle must not appear.
- Opcode 0000011 -> cdb_valid=1, cdb_data=0, illegal_op=1.
- With ALU_EXEC_PERF_EN: 4 completed ops and 2 stalled-issue cycles -> ops_done=4, stall_cycles=2.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU pipe (RR operand stage, WB result register) from RS issue to the CDB.
// Define ALU_EXEC_PERF_EN to add the ops_done / stall_cycles performance counters.
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 8,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              alu_rdy,
  input  logic [6:0]        issue_opcode,
  input  logic [2:0]        issue_func3,
  input  logic [6:0]        issue_func7,
  input  logic [PREG_W-1:0] issue_prd,
  input  logic [PREG_W-1:0] issue_pr1,
  input  logic [PREG_W-1:0] issue_pr2,
  input  logic [XLEN-1:0]   issue_imm,
  input  logic [ROB_W-1:0]  issue_rob_index,
  output logic [PREG_W-1:0] prf_raddr1,
  output logic [PREG_W-1:0] prf_raddr2,
  input  logic [XLEN-1:0]   prf_rdata1,
  input  logic [XLEN-1:0]   prf_rdata2,
  input  logic              flush,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [PREG_W-1:0] cdb_prd,
  output logic [XLEN-1:0]   cdb_data,
  output logic [ROB_W-1:0]  cdb_rob_index,
`ifdef ALU_EXEC_PERF_EN
  output logic [31:0]       ops_done,
  output logic [31:0]       stall_cycles,
`endif
  output logic              illegal_op
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  logic              r_rr_valid, r_fresh, r_f7b5;
  logic [6:0]        r_opcode;
  logic [2:0]        r_func3;
  logic [PREG_W-1:0] r_prd;
  logic [ROB_W-1:0]  r_rob;
  logic [XLEN-1:0]   r_imm, r_a, r_b;
  logic              r_wb_valid, r_wb_ill;
  logic [PREG_W-1:0] r_wb_prd;
  logic [ROB_W-1:0]  r_wb_rob;
  logic [XLEN-1:0]   r_wb_data;
  logic              w_accept, w_rr_adv, w_is_r, w_is_i, w_is_lui, w_alt, w_illegal, w_unused;
  logic [XLEN-1:0]   w_a, w_rs2, w_b, w_sra, w_alu, w_result;
  logic [4:0]        w_shamt;
  assign w_rr_adv   = r_rr_valid && (!r_wb_valid || cdb_ready);
  assign alu_rdy    = !flush && (!r_rr_valid || w_rr_adv);
  assign w_accept   = issue_valid && alu_rdy;
  assign prf_raddr1 = issue_pr1;
  assign prf_raddr2 = issue_pr2;
  assign w_unused   = ^{issue_func7[6], issue_func7[4:0]};
  // PRF data arrives during the op's first RR cycle; afterwards the captured copy is used
  assign w_a      = r_fresh ? prf_rdata1 : r_a;
  assign w_rs2    = r_fresh ? prf_rdata2 : r_b;
  assign w_is_r   = r_opcode == OP_R;
  assign w_is_i   = r_opcode == OP_I;
  assign w_is_lui = r_opcode == OP_LUI;
  assign w_b      = w_is_i ? r_imm : w_rs2;
  assign w_shamt  = w_b[4:0];
  assign w_alt    = w_is_r ? r_f7b5 : r_imm[10];
  assign w_sra    = $signed(w_a) >>> w_shamt;
  always_comb begin
    w_alu = '0;
    case (r_func3)
      3'b000:  w_alu = (w_is_r && r_f7b5) ? w_a - w_b : w_a + w_b;
      3'b001:  w_alu = w_a << w_shamt;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
      3'b100:  w_alu = w_a ^ w_b;
      3'b101:  w_alu = w_alt ? w_sra : w_a >> w_shamt;
      3'b110:  w_alu = w_a | w_b;
      default: w_alu = w_a & w_b;
    endcase
  end
  assign w_illegal = !(w_is_r || w_is_i || w_is_lui);
  assign w_result  = (w_is_r || w_is_i) ? w_alu : w_is_lui ? r_imm : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_valid <= 1'b0;
      r_fresh    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_ill   <= 1'b0;
      r_wb_prd   <= '0;
      r_wb_rob   <= '0;
      r_wb_data  <= '0;
    end else begin
      r_fresh <= w_accept;
      if (r_fresh) begin
        r_a <= prf_rdata1;
        r_b <= prf_rdata2;
      end
      if (flush) r_rr_valid <= 1'b0;
      else if (w_accept) r_rr_valid <= 1'b1;
      else if (w_rr_adv) r_rr_valid <= 1'b0;
      if (w_accept) begin
        r_opcode <= issue_opcode;
        r_func3  <= issue_func3;
        r_f7b5   <= issue_func7[5];
        r_prd    <= issue_prd;
        r_rob    <= issue_rob_index;
        r_imm    <= issue_imm;
      end
      if (flush) r_wb_valid <= 1'b0;
      else if (w_rr_adv) r_wb_valid <= 1'b1;
      else if (cdb_ready) r_wb_valid <= 1'b0;
      if (w_rr_adv && !flush) begin
        r_wb_data <= w_result;
        r_wb_ill  <= w_illegal;
        r_wb_prd  <= r_prd;
        r_wb_rob  <= r_rob;
      end
    end
  end
  assign cdb_valid     = r_wb_valid;
  assign cdb_data      = r_wb_data;
  assign cdb_prd       = r_wb_prd;
  assign cdb_rob_index = r_wb_rob;
  assign illegal_op    = r_wb_ill;
`ifdef ALU_EXEC_PERF_EN
  logic [31:0] r_ops_done, r_stall_cycles;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ops_done     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_wb_valid && cdb_ready) r_ops_done <= r_ops_done + 32'd1;
      if (issue_valid && !alu_rdy) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
  assign ops_done     = r_ops_done;
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPLUI = 7'b0110111;
  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [7:0]  prd, pr1, pr2;
    logic [31:0] imm;
    logic [3:0]  rob;
  } op_t;
  typedef struct {
    logic [7:0]  prd;
    logic [3:0]  rob;
    logic [31:0] data;
    logic        ill;
    logic        in_wb;
  } ent_t;
  logic        clk, reset, issue_valid, alu_rdy, flush, cdb_valid, cdb_ready, illegal_op;
  logic [6:0]  issue_opcode, issue_func7;
  logic [2:0]  issue_func3;
  logic [7:0]  issue_prd, issue_pr1, issue_pr2, prf_raddr1, prf_raddr2, cdb_prd;
  logic [31:0] issue_imm, prf_rdata1, prf_rdata2, cdb_data;
  logic [3:0]  issue_rob_index, cdb_rob_index;
`ifdef ALU_EXEC_PERF_EN
  logic [31:0] ops_done, stall_cycles;
`endif
  logic [31:0] prf [256];
  ent_t        q[$];
  int          n_checks = 0, n_errors = 0, m_done = 0, m_stalls = 0;
  alu_exec_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .alu_rdy(alu_rdy),
    .issue_opcode(issue_opcode), .issue_func3(issue_func3), .issue_func7(issue_func7),
    .issue_prd(issue_prd), .issue_pr1(issue_pr1), .issue_pr2(issue_pr2),
    .issue_imm(issue_imm), .issue_rob_index(issue_rob_index),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_prd(cdb_prd),
    .cdb_data(cdb_data), .cdb_rob_index(cdb_rob_index),
`ifdef ALU_EXEC_PERF_EN
    .ops_done(ops_done), .stall_cycles(stall_cycles),
`endif
    .illegal_op(illegal_op)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // synchronous-read register file model
  always @(posedge clk) begin
    prf_rdata1 <= prf[prf_raddr1];
    prf_rdata2 <= prf[prf_raddr2];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [7:0] prd, input logic [7:0] pr1, input logic [7:0] pr2,
                             input logic [31:0] imm, input logic [3:0] rob);
    op_t o;
    o.opc = opc; o.f3 = f3; o.f7 = f7; o.prd = prd; o.pr1 = pr1; o.pr2 = pr2; o.imm = imm; o.rob = rob;
    return o;
  endfunction
  // {illegal, result} from the RV32I rules
  function automatic logic [32:0] ref_exec(input op_t o, input logic [31:0] a, input logic [31:0] r2);
    logic [31:0] b, res;
    logic [63:0] ext;
    logic        alt;
    b   = (o.opc == OPI) ? o.imm : r2;
    alt = (o.opc == OPR) ? o.f7[5] : o.imm[10];
    ext = {{32{a[31]}}, a} >> b[4:0];
    case (o.f3)
      3'd0:    res = (o.opc == OPR && o.f7[5]) ? a - b : a + b;
      3'd1:    res = a << b[4:0];
      3'd2:    res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3:    res = (a < b) ? 32'd1 : 32'd0;
      3'd4:    res = a ^ b;
      3'd5:    res = alt ? ext[31:0] : a >> b[4:0];
      3'd6:    res = a | b;
      default: res = a & b;
    endcase
    if (o.opc == OPLUI) return {1'b0, o.imm};
    if (o.opc != OPR && o.opc != OPI) return {1'b1, 32'd0};
    return {1'b0, res};
  endfunction
  task automatic tick(input logic iv, input op_t o, input logic rdy, input logic fl);
    logic er, ev;
    logic [32:0] r;
    ent_t e;
    @(negedge clk);
    issue_valid = iv; issue_opcode = o.opc; issue_func3 = o.f3; issue_func7 = o.f7;
    issue_prd = o.prd; issue_pr1 = o.pr1; issue_pr2 = o.pr2; issue_imm = o.imm;
    issue_rob_index = o.rob; cdb_ready = rdy; flush = fl;
    #1;
    er = !fl && (q.size() < 2 || rdy);
    ev = q.size() > 0 && q[0].in_wb;
    check("alu_rdy", alu_rdy, er);
    check("cdb_valid", cdb_valid, ev);
    if (ev) begin
      check("cdb_data", cdb_data, q[0].data);
      check("cdb_prd", cdb_prd, q[0].prd);
      check("cdb_rob", cdb_rob_index, q[0].rob);
      check("illegal_op", illegal_op, q[0].ill);
    end
    if (iv && !er) m_stalls++;
    if (ev && rdy) begin
      void'(q.pop_front());
      m_done++;
    end
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && !q[0].in_wb) begin
        e = q[0]; e.in_wb = 1'b1; q[0] = e;
      end
      if (iv && er) begin
        r = ref_exec(o, prf[o.pr1], prf[o.pr2]);
        e.prd = o.prd; e.rob = o.rob; e.data = r[31:0]; e.ill = r[32]; e.in_wb = 1'b0;
        q.push_back(e);
      end
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; issue_valid = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete(); m_done = 0; m_stalls = 0;
    #1;
    check("rst_rdy", alu_rdy, 1);
    check("rst_valid", cdb_valid, 0);
    check("rst_data", cdb_data, 0);
    check("rst_prd", cdb_prd, 0);
    check("rst_rob", cdb_rob_index, 0);
    check("rst_ill", illegal_op, 0);
  endtask
  task automatic dir(input op_t o, input logic [31:0] want, input string tag);
    tick(1'b1, o, 1'b1, 1'b0);
    tick(1'b0, o, 1'b1, 1'b0);
    tick(1'b0, o, 1'b1, 1'b0);
    check(tag, cdb_data, want);
  endtask
  function automatic op_t rand_op();
    op_t o;
    int sel;
    sel   = $urandom_range(0, 9);
    o.opc = sel < 4 ? OPR : sel < 8 ? OPI : sel == 8 ? OPLUI : 7'($urandom);
    o.f3  = 3'($urandom);
    o.f7  = $urandom_range(0, 3) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
    o.imm = $urandom;
    if (o.opc == OPI) o.imm = {{20{o.imm[11]}}, o.imm[11:0]};
    if (o.opc == OPLUI) o.imm[11:0] = 12'd0;
    o.prd = 8'($urandom); o.pr1 = 8'($urandom); o.pr2 = 8'($urandom); o.rob = 4'($urandom);
    return o;
  endfunction
  initial begin
    op_t a, b, c, o;
    for (int i = 0; i < 256; i++) prf[i] = $urandom;
    prf[1] = 32'd5; prf[2] = 32'd7; prf[3] = 32'd3; prf[4] = 32'h8000_0000;
    prf[5] = 32'd4; prf[6] = 32'd1; prf[7] = 32'hFFFF_FFFF;
    reset = 1'b1; issue_valid = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    issue_opcode = '0; issue_func3 = '0; issue_func7 = '0; issue_prd = '0;
    issue_pr1 = '0; issue_pr2 = '0; issue_imm = '0; issue_rob_index = '0;
    do_reset();
    a = mk(OPR, 3'd0, 7'h00, 8'd12, 8'd1, 8'd2, 32'd0, 4'd3);
    dir(a, 32'd12, "add");
    check("add_prd", cdb_prd, 12);
    check("add_rob", cdb_rob_index, 3);
    dir(mk(OPR, 3'd0, 7'h20, 8'd13, 8'd3, 8'd1, 32'd0, 4'd4), 32'hFFFF_FFFE, "sub");
    dir(mk(OPR, 3'd5, 7'h20, 8'd14, 8'd4, 8'd5, 32'd0, 4'd5), 32'hF800_0000, "sra");
    dir(mk(OPR, 3'd3, 7'h00, 8'd15, 8'd6, 8'd7, 32'd0, 4'd6), 32'd1, "sltu");
    dir(mk(OPI, 3'd5, 7'h20, 8'd16, 8'd4, 8'd0, 32'h404, 4'd7), 32'hF800_0000, "srai");
    dir(mk(OPLUI, 3'd0, 7'h00, 8'd17, 8'd0, 8'd0, 32'h1234_5000, 4'd8), 32'h1234_5000, "lui");
    dir(mk(7'b0000011, 3'd2, 7'h00, 8'd18, 8'd1, 8'd2, 32'd8, 4'd9), 32'd0, "illegal_data");
    check("illegal_flag", illegal_op, 1);
    a = mk(OPR, 3'd0, 7'h00, 8'd20, 8'd1, 8'd2, 32'd0, 4'd1);
    b = mk(OPR, 3'd0, 7'h20, 8'd21, 8'd3, 8'd1, 32'd0, 4'd2);
    c = mk(OPR, 3'd3, 7'h00, 8'd22, 8'd6, 8'd7, 32'd0, 4'd3);
    tick(1'b1, a, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
    tick(1'b1, c, 1'b0, 1'b0);
    check("bp_rdy", alu_rdy, 0);
    check("bp_hold", cdb_data, 12);
    tick(1'b1, c, 1'b0, 1'b0);
    check("bp_hold2", cdb_data, 12);
    tick(1'b1, c, 1'b1, 1'b0);
    repeat (4) tick(1'b0, c, 1'b1, 1'b0);
    tick(1'b1, a, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
    tick(1'b1, c, 1'b0, 1'b1);
    check("flush_rdy", alu_rdy, 0);
    tick(1'b0, c, 1'b1, 1'b0);
    check("flush_cdb", cdb_valid, 0);
    repeat (3) tick(1'b0, c, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      o = rand_op();
      tick($urandom_range(0, 3) != 0, o, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
`ifdef ALU_EXEC_PERF_EN
    check("ops_done", ops_done, m_done);
    check("stall_cycles", stall_cycles, m_stalls);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
